fetch_stage: RTL

Instruction-fetch stage of the pipelined MIPS core. It sits directly upstream of the instruction ROM: it owns the PC, drives the ROM address, and latches the returned word into the IF/ID register for decode. It also selects the next PC from sequential, branch/jump redirect, interrupt and exception vectors, and it tracks the supervisor bit (PC[31]).

---
 rtl/cpu_defs.sv | 13 +
 rtl/next_pc_sel.sv | 51 +++++
 rtl/fetch_stage.sv | 63 ++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared constants for the MIPS core front end: fixed vectors, bubble word, mode bit.
package cpu_defs;
  localparam logic [31:0] RESET_VEC      = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC        = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC        = 32'h8000_0008;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam int          SUPERVISOR_BIT = 31;

  // Sequential successor; the mode bit is never carried into.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return {pc[SUPERVISOR_BIT], pc[30:0] + 31'd4};
  endfunction
endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux: exception > irq > redirect > stall > sequential.
import cpu_defs::*;

module next_pc_sel #(
  parameter logic [31:0] IRQ_VEC = cpu_defs::IRQ_VEC,
  parameter logic [31:0] EXC_VEC = cpu_defs::EXC_VEC
) (
  input  logic [31:0] pc,
  input  logic [31:0] pc4,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        exc_req,
  input  logic [31:0] exc_epc,
  input  logic        irq,
  input  logic        irq_ack,
  output logic [31:0] next_pc,
  output logic        flush,
  output logic        hold,
  output logic        accept_irq,
  output logic        epc_load,
  output logic [31:0] epc_next
);
  // irq_ack still high means the handler has not run yet; block re-entry.
  assign accept_irq = irq && !pc[SUPERVISOR_BIT] && !stall && !irq_ack && !exc_req;

  always_comb begin
    next_pc  = pc4;
    flush    = 1'b0;
    hold     = 1'b0;
    epc_load = 1'b0;
    epc_next = exc_epc;
    if (exc_req) begin
      next_pc  = EXC_VEC;
      flush    = 1'b1;
      epc_load = 1'b1;
    end else if (accept_irq) begin
      next_pc  = IRQ_VEC;
      flush    = 1'b1;
      epc_load = 1'b1;
      epc_next = redirect ? redirect_target : pc;
    end else if (redirect) begin
      // A jump can leave supervisor mode but never enter it.
      next_pc  = {pc[SUPERVISOR_BIT] & redirect_target[SUPERVISOR_BIT], redirect_target[30:0]};
      flush    = 1'b1;
    end else if (stall) begin
      next_pc  = pc;
      hold     = 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM, fills IF/ID, tracks epc and mode.
import cpu_defs::*;

module fetch_stage #(
  parameter logic [31:0] RESET_VEC = cpu_defs::RESET_VEC,
  parameter logic [31:0] IRQ_VEC   = cpu_defs::IRQ_VEC,
  parameter logic [31:0] EXC_VEC   = cpu_defs::EXC_VEC,
  parameter logic [31:0] NOP_INSTR = cpu_defs::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        exc_req,
  input  logic [31:0] exc_epc,
  input  logic        irq,
  output logic        irq_ack,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] epc,
  output logic        supervisor
);
  logic [31:0] pc, pc4, next_pc, epc_next;
  logic        flush, hold, accept_irq, epc_load;

  assign pc4        = seq_pc(pc);
  assign rom_addr   = pc;
  assign supervisor = pc[SUPERVISOR_BIT];

  next_pc_sel #(.IRQ_VEC(IRQ_VEC), .EXC_VEC(EXC_VEC)) u_sel (
    .pc(pc), .pc4(pc4), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .exc_req(exc_req), .exc_epc(exc_epc),
    .irq(irq), .irq_ack(irq_ack), .next_pc(next_pc), .flush(flush),
    .hold(hold), .accept_irq(accept_irq), .epc_load(epc_load), .epc_next(epc_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_VEC;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      epc         <= '0;
      irq_ack     <= 1'b0;
    end else begin
      irq_ack <= accept_irq;
      if (!hold) pc <= next_pc;
      if (epc_load) epc <= epc_next;
      if (flush) begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end else if (!hold) begin
        if_id_instr <= rom_data;
        if_id_pc4   <= pc4;
        if_id_valid <= 1'b1;
      end
    end
  end
endmodule
